// File: rtl/rtc_calendar_counter_if.sv
// Bundle between the RTC calendar core and its environment.
// btn_mode / btn_inc : debounced button levels into the core
// cnt_*              : binary field values for the BCD display stage
// enable_*           : per-field display enables (1 = show digits)
// set_active         : high while any field is being set
// master modport: button driver / display side. slave modport: the core.
interface rtc_calendar_counter_if;
  logic       btn_mode;
  logic       btn_inc;
  logic [5:0] cnt_s;
  logic [5:0] cnt_mi;
  logic [5:0] cnt_h;
  logic [5:0] cnt_d;
  logic [5:0] cnt_mo;
  logic [6:0] cnt_y_ten_unit;
  logic [6:0] cnt_y_thousand_hundred;
  logic       enable_s;
  logic       enable_mi;
  logic       enable_h;
  logic       enable_d;
  logic       enable_mo;
  logic       enable_y;
  logic       set_active;

  modport master (
    output btn_mode, btn_inc,
    input  cnt_s, cnt_mi, cnt_h, cnt_d, cnt_mo, cnt_y_ten_unit, cnt_y_thousand_hundred,
    input  enable_s, enable_mi, enable_h, enable_d, enable_mo, enable_y, set_active
  );

  modport slave (
    input  btn_mode, btn_inc,
    output cnt_s, cnt_mi, cnt_h, cnt_d, cnt_mo, cnt_y_ten_unit, cnt_y_thousand_hundred,
    output enable_s, enable_mi, enable_h, enable_d, enable_mo, enable_y, set_active
  );
endinterface

// File: rtl/rtc_calendar_counter.sv
// Real-time clock / calendar core feeding the binary-to-BCD display stage.
// Keeps s, mi, h, d, mo and a four-digit year (two 0..99 halves) with leap years.
// A button-driven set mode walks Y -> MO -> D -> H -> MI; the selected field blinks.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : rtc_calendar_counter_if.slave (buttons in, counts/enables/set_active out)
// Optional feature: define AUTO_REPEAT_EN to auto-repeat btn_inc while held in a set
// state (first repeat after CLK_HZ cycles, then every CLK_HZ/4 cycles).
module rtc_calendar_counter #(
  parameter int unsigned CLK_HZ      = 50000000,
  parameter int unsigned RST_YEAR_HI = 20,
  parameter int unsigned RST_YEAR_LO = 0
) (
  input logic                   clk,
  input logic                   rst_n,
  rtc_calendar_counter_if.slave bus
);

  localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PrescMax  = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] PrescHalf = PW'(CLK_HZ / 2);

  typedef enum logic [2:0] {StRun, StSetY, StSetMo, StSetD, StSetH, StSetMi} state_e;

  function automatic logic [5:0] days_in_month(input logic [5:0] mo, input logic [6:0] lo,
                                               input logic [6:0] hi);
    logic leap;
    // Century years are leap only when the hundreds pair is a multiple of 4.
    leap = (lo != 7'd0) ? (lo[1:0] == 2'b00) : (hi[1:0] == 2'b00);
    case (mo)
      6'd4, 6'd6, 6'd9, 6'd11: days_in_month = 6'd30;
      6'd2:                    days_in_month = leap ? 6'd29 : 6'd28;
      default:                 days_in_month = 6'd31;
    endcase
  endfunction

  // Returns {hi, lo} of the following year; 9999 wraps to 0000.
  function automatic logic [13:0] year_next(input logic [6:0] hi, input logic [6:0] lo);
    if (lo == 7'd99) year_next = {((hi == 7'd99) ? 7'd0 : hi + 7'd1), 7'd0};
    else             year_next = {hi, lo + 7'd1};
  endfunction

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          mode_q, inc_q;
  logic [5:0]    s_q, s_d, mi_q, mi_d, h_q, h_d, d_q, d_d, mo_q, mo_d;
  logic [6:0]    y_lo_q, y_lo_d, y_hi_q, y_hi_d;
  logic          en_s_q, en_mi_q, en_h_q, en_d_q, en_mo_q, en_y_q, set_active_q;
  logic          en_s_d, en_mi_d, en_h_d, en_d_d, en_mo_d, en_y_d, set_active_d;

  logic        mode_edge, inc_edge, tick, rep_fire, blank;
  logic [13:0] y_inc;
  logic [5:0]  dim_cur, dim_new, mo_inc;

  assign mode_edge = bus.btn_mode & ~mode_q;
  assign inc_edge  = bus.btn_inc & ~inc_q;
  assign tick      = (presc_q == PrescMax);

`ifdef AUTO_REPEAT_EN
  localparam int unsigned Rep = (CLK_HZ / 4 > 0) ? CLK_HZ / 4 : 1;
  localparam int unsigned HW  = $clog2(CLK_HZ + 1);
  logic [HW-1:0] hold_q, hold_d;

  // hold_q counts cycles btn_inc has been held in the current set state.
  always_comb begin
    hold_d   = '0;
    rep_fire = 1'b0;
    if (state_q != StRun && bus.btn_inc && !mode_edge) begin
      if (hold_q == HW'(CLK_HZ)) begin
        rep_fire = 1'b1;
        hold_d   = HW'(CLK_HZ - Rep + 1);
      end else begin
        hold_d = hold_q + HW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_q <= '0;
    else        hold_q <= hold_d;
  end
`else
  assign rep_fire = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StRun;
    else        state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    if (mode_edge) begin
      unique case (state_q)
        StRun:   state_d = StSetY;
        StSetY:  state_d = StSetMo;
        StSetMo: state_d = StSetD;
        StSetD:  state_d = StSetH;
        StSetH:  state_d = StSetMi;
        default: state_d = StRun;
      endcase
    end
  end

  // Next-state outputs; registered so the enables line up with presc_q / state_q.
  always_comb begin
    blank        = (presc_d >= PrescHalf);
    en_s_d       = 1'b1;
    en_y_d       = !(state_d == StSetY && blank);
    en_mo_d      = !(state_d == StSetMo && blank);
    en_d_d       = !(state_d == StSetD && blank);
    en_h_d       = !(state_d == StSetH && blank);
    en_mi_d      = !(state_d == StSetMi && blank);
    set_active_d = (state_d != StRun);
  end

  // Calendar datapath.
  always_comb begin
    presc_d = tick ? '0 : presc_q + PW'(1);
    s_d     = s_q;
    mi_d    = mi_q;
    h_d     = h_q;
    d_d     = d_q;
    mo_d    = mo_q;
    y_lo_d  = y_lo_q;
    y_hi_d  = y_hi_q;
    y_inc   = year_next(y_hi_q, y_lo_q);
    dim_cur = days_in_month(mo_q, y_lo_q, y_hi_q);
    dim_new = dim_cur;
    mo_inc  = (mo_q == 6'd12) ? 6'd1 : mo_q + 6'd1;

    if (state_q == StRun) begin
      if (tick) begin
        if (s_q == 6'd59) begin
          s_d = 6'd0;
          if (mi_q == 6'd59) begin
            mi_d = 6'd0;
            if (h_q == 6'd23) begin
              h_d = 6'd0;
              if (d_q >= dim_cur) begin
                d_d  = 6'd1;
                mo_d = mo_inc;
                if (mo_q == 6'd12) begin
                  y_hi_d = y_inc[13:7];
                  y_lo_d = y_inc[6:0];
                end
              end else begin
                d_d = d_q + 6'd1;
              end
            end else begin
              h_d = h_q + 6'd1;
            end
          end else begin
            mi_d = mi_q + 6'd1;
          end
        end else begin
          s_d = s_q + 6'd1;
        end
      end
    end else if ((inc_edge | rep_fire) & ~mode_edge) begin
      unique case (state_q)
        StSetY: begin
          y_hi_d  = y_inc[13:7];
          y_lo_d  = y_inc[6:0];
          dim_new = days_in_month(mo_q, y_inc[6:0], y_inc[13:7]);
          if (d_q > dim_new) d_d = dim_new;
        end
        StSetMo: begin
          mo_d    = mo_inc;
          dim_new = days_in_month(mo_inc, y_lo_q, y_hi_q);
          if (d_q > dim_new) d_d = dim_new;
        end
        StSetD:  d_d  = (d_q >= dim_cur) ? 6'd1 : d_q + 6'd1;
        StSetH:  h_d  = (h_q == 6'd23) ? 6'd0 : h_q + 6'd1;
        StSetMi: mi_d = (mi_q == 6'd59) ? 6'd0 : mi_q + 6'd1;
        default: ;
      endcase
    end

    // Returning to RUN restarts the current second from zero.
    if (mode_edge && state_q == StSetMi) begin
      s_d     = 6'd0;
      presc_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      mode_q  <= 1'b0;
      inc_q   <= 1'b0;
      s_q     <= 6'd0;
      mi_q    <= 6'd0;
      h_q     <= 6'd0;
      d_q     <= 6'd1;
      mo_q    <= 6'd1;
      y_lo_q  <= 7'(RST_YEAR_LO);
      y_hi_q  <= 7'(RST_YEAR_HI);
    end else begin
      presc_q <= presc_d;
      mode_q  <= bus.btn_mode;
      inc_q   <= bus.btn_inc;
      s_q     <= s_d;
      mi_q    <= mi_d;
      h_q     <= h_d;
      d_q     <= d_d;
      mo_q    <= mo_d;
      y_lo_q  <= y_lo_d;
      y_hi_q  <= y_hi_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_s_q       <= 1'b1;
      en_mi_q      <= 1'b1;
      en_h_q       <= 1'b1;
      en_d_q       <= 1'b1;
      en_mo_q      <= 1'b1;
      en_y_q       <= 1'b1;
      set_active_q <= 1'b0;
    end else begin
      en_s_q       <= en_s_d;
      en_mi_q      <= en_mi_d;
      en_h_q       <= en_h_d;
      en_d_q       <= en_d_d;
      en_mo_q      <= en_mo_d;
      en_y_q       <= en_y_d;
      set_active_q <= set_active_d;
    end
  end

  assign bus.cnt_s                  = s_q;
  assign bus.cnt_mi                 = mi_q;
  assign bus.cnt_h                  = h_q;
  assign bus.cnt_d                  = d_q;
  assign bus.cnt_mo                 = mo_q;
  assign bus.cnt_y_ten_unit         = y_lo_q;
  assign bus.cnt_y_thousand_hundred = y_hi_q;
  assign bus.enable_s               = en_s_q;
  assign bus.enable_mi              = en_mi_q;
  assign bus.enable_h               = en_h_q;
  assign bus.enable_d               = en_d_q;
  assign bus.enable_mo              = en_mo_q;
  assign bus.enable_y               = en_y_q;
  assign bus.set_active             = set_active_q;

endmodule

// File: doc/rtc_calendar_counter.md
Name: rtc_calendar_counter

Overview:
Real-time clock/calendar core that drives the binary-to-BCD display stage. Keeps seconds, minutes, hours, day, month and a four-digit year, with leap-year handling. Provides a button-driven set mode in which the selected field blinks by toggling its display-enable output. All count and enable outputs connect one-to-one to the BCD stage inputs.

Parameters:
CLK_HZ, 50000000, input clock frequency; prescaler period for the 1 s tick
RST_YEAR_HI, 20, year hundreds/thousands pair loaded at reset (0..99)
RST_YEAR_LO, 0, year tens/units pair loaded at reset (0..99)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
btn_mode  in  1  debounced level; rising edge advances the set-mode state
btn_inc  in  1  debounced level; rising edge increments the selected field
cnt_s, cnt_mi, cnt_h  out  6  seconds 0-59, minutes 0-59, hours 0-23
cnt_d, cnt_mo  out  6  day 1-28/29/30/31, month 1-12
cnt_y_ten_unit  out  7  year mod 100 (0-99)
cnt_y_thousand_hundred  out  7  year div 100 (0-99)
enable_s, enable_mi, enable_h, enable_d, enable_mo, enable_y  out  1  display enables; 1 = show digits
set_active  out  1  high in any SET state

Behaviour:
- One clock domain. Reset is asynchronous and active-low: clk, rst_n.
- Reset values: 00:00:00, day 1, month 1, year RST_YEAR_HI:RST_YEAR_LO. Prescaler is 0. FSM is RUN. All enables are 1. set_active is 0. Button edge registers are 0.
- Reset asserted mid-operation clears everything immediately, including when in a set state.
- Prescaler counts 0..CLK_HZ-1 and wraps. tick is high for one cycle when the prescaler equals CLK_HZ-1.
- All outputs are registered. A field updated on a tick or edge appears on the outputs the following cycle.
- Button edges are detected internally as (level & ~previous level). One increment occurs per edge.
- FSM: RUN -> SET_Y -> SET_MO -> SET_D -> SET_H -> SET_MI -> RUN. Each transition happens on a btn_mode edge.
- RUN: on each tick, s+1. 59 wraps to 0 and carries to mi. Minutes 59 -> 0 carries to h. Hours 23 -> 0 carries to d. Day at dim -> 1 carries to mo. Month 12 -> 1 carries to year. btn_inc is ignored.
- Year increment: y_lo+1; 99 -> 0 carries to y_hi+1; y_hi 99 -> 0 (9999 wraps to 0000).
- dim (days in month): 31 for months 1,3,5,7,8,10,12; 30 for months 4,6,9,11; 29 for Feb in a leap year, else 28.
- Leap year: (y_lo != 0 && y_lo%4 == 0) || (y_lo == 0 && y_hi%4 == 0).
- SET states: time is frozen; ticks do not advance any field, but the prescaler keeps running for blinking. btn_inc increments only the selected field, with wrap and no carry: h 23->0, mi 59->0, d dim->1, mo 12->1. Year increments with the carry rule above.
- Day clamp: after any month or year change in a SET state, if d > new dim then d = dim, applied in the same update.
- Blink: the selected field's enable = (prescaler < CLK_HZ/2). All other enables = 1. In RUN, all enables = 1.
- Leaving SET_MI for RUN: s = 0 and prescaler = 0 in that cycle.
- btn_mode and btn_inc edges in the same cycle: the mode edge wins and the inc edge is dropped.
- set_active = (state != RUN).

Optional Feature:
AUTO_REPEAT_EN. When defined, holding btn_inc high continuously for CLK_HZ cycles in a SET state produces one extra increment. After that, one increment follows every CLK_HZ/4 cycles while the button is held. Releasing the button or changing state clears the hold counter. When not defined, only rising edges increment and the hold counter is not built.

Test Plan:
1. Reset with CLK_HZ=10: release rst_n -> outputs 0,0,0,1,1,0,20; enables all 1; set_active 0. Assert rst_n while in SET_D -> same values immediately.
2. Rollover: set 31/12/2099 23:59:59, then one tick -> 00:00:00, d=1, mo=1, y_lo=0, y_hi=21.
3. Leap: from 28/02 23:59:59 in 2024, one tick -> 29/02. In 2100, one tick -> 01/03. In 2000, one tick -> 29/02. From 29/02/2024 23:59:59, one tick -> 01/03.
4. Clamp: in SET_MO with d=31, mo=3, one inc -> mo=4, d=30. In SET_Y with 29/02/2024, one inc -> 2025, d=28.
5. Set/blink: enter SET_MI -> enable_mi low for prescaler 5..9, other enables high, s frozen across ticks. mode and inc in the same cycle -> state advances to RUN, mi unchanged, s=0.
6. With AUTO_REPEAT_EN defined: in SET_H, hold btn_inc for 20 cycles -> h increases by 1 at the edge, 1 at cycle 10, 1 at cycles 12 and 14, and so on. Without the macro -> h increases by exactly 1.
